// File: rtl/ddr_to_rgb_pkg.sv
// Shared MCB definitions for the DDR frame-buffer reader and writer:
// MCB command instruction codes and the depth of the MCB user-port FIFOs.
package ddr_to_rgb_pkg;

    localparam logic [2:0] MCB_INSTR_WRITE                = 3'b000;
    localparam logic [2:0] MCB_INSTR_READ                 = 3'b001;
    localparam logic [2:0] MCB_INSTR_WRITE_AUTO_PRECHARGE = 3'b010;
    localparam logic [2:0] MCB_INSTR_READ_AUTO_PRECHARGE  = 3'b011;

    localparam int MCB_FIFO_DEPTH = 64;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI4-Stream output register. A load captures a new beat;
// the beat is held unchanged until the sink accepts it.
module axis_out_reg #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             user_in,
    input  logic             last_in,
    input  logic             tready,
    output logic [WIDTH-1:0] tdata,
    output logic             tvalid,
    output logic             tuser,
    output logic             tlast
);

    // Valid rises on a load and falls only after a handshake with no new load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

    // Payload changes only on a load, so it stays stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata <= '0;
            tuser <= 1'b0;
            tlast <= 1'b0;
        end else if (load) begin
            tdata <= din;
            tuser <= user_in;
            tlast <= last_in;
        end
    end

endmodule

// File: rtl/ddr_to_rgb.sv
// DDR frame reader: issues fixed-length READ bursts on MCB port 1, walking the
// stored frame from the base address and wrapping at frame end, and streams
// the returned words out as AXI4-Stream pixels with SOF on tuser, EOF on tlast.
module ddr_to_rgb import ddr_to_rgb_pkg::*; #(
    parameter int RGB_WIDTH       = 24,
    parameter int BURST_LEN       = 64,
    parameter int FRAME_WORDS     = 307200,
    parameter int FRAME_BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c3_calib_done,
    output logic                 c3_p1_cmd_en,
    output logic [2:0]           c3_p1_cmd_instr,
    output logic [5:0]           c3_p1_cmd_bl,
    output logic [29:0]          c3_p1_cmd_byte_addr,
    input  logic                 c3_p1_cmd_empty,
    input  logic                 c3_p1_cmd_full,
    output logic                 c3_p1_rd_en,
    input  logic [31:0]          c3_p1_rd_data,
    input  logic                 c3_p1_rd_empty,
    input  logic                 c3_p1_rd_full,
    input  logic [6:0]           c3_p1_rd_count,
    input  logic                 c3_p1_rd_overflow,
    input  logic                 c3_p1_rd_error,
    output logic [RGB_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic [7:0]           led
);

    localparam int PIX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int WL_W  = $clog2(MCB_FIFO_DEPTH) + 1;

    localparam logic [PIX_W-1:0] LAST_PIX    = PIX_W'(FRAME_WORDS - 1);
    localparam logic [29:0]      BASE_ADDR   = 30'(FRAME_BASE_ADDR);
    localparam logic [29:0]      BURST_BYTES = 30'(BURST_LEN * 4);
    localparam logic [WL_W-1:0]  BURST_WORDS = WL_W'(BURST_LEN);
    localparam logic [5:0]       CMD_BL      = 6'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_WAIT_CALIB,
        ST_CMD,
        ST_STREAM
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [29:0]       addr;
    logic [WL_W-1:0]   words_left;
    logic [PIX_W-1:0]  pixel_idx;
    logic [5:0]        frame_count;
    logic              err_sticky;
    logic              calib_q;
    logic              cmd_go;
    logic              load;
    logic              flush_pop;
    logic              unused_inputs;

    assign unused_inputs = &{1'b0, c3_p1_rd_full, c3_p1_rd_data};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush stale data, wait for calibration, then alternate command / stream
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FLUSH:      if (c3_p1_rd_empty && c3_p1_cmd_empty) state_nxt = ST_WAIT_CALIB;
            ST_WAIT_CALIB: if (c3_calib_done) state_nxt = ST_CMD;
            ST_CMD:        if (cmd_go) state_nxt = ST_STREAM;
            ST_STREAM:     if (words_left == '0) state_nxt = ST_CMD;
            default:       state_nxt = ST_FLUSH;
        endcase
    end

    // State outputs: command issue only with an empty read FIFO keeps one burst in flight
    always_comb begin
        cmd_go    = 1'b0;
        load      = 1'b0;
        flush_pop = 1'b0;
        case (state)
            ST_FLUSH:  flush_pop = !c3_p1_rd_empty;
            ST_CMD:    cmd_go    = !c3_p1_cmd_full && (c3_p1_rd_count == 7'd0);
            ST_STREAM: load      = !c3_p1_rd_empty && (words_left != '0) &&
                                   (!m_axis_tvalid || m_axis_tready);
            default:   ;
        endcase
    end

    assign c3_p1_rd_en         = rst_n && (flush_pop || load);
    assign c3_p1_cmd_en        = cmd_go;
    assign c3_p1_cmd_instr     = cmd_go ? MCB_INSTR_READ : 3'b000;
    assign c3_p1_cmd_bl        = cmd_go ? CMD_BL : 6'd0;
    assign c3_p1_cmd_byte_addr = cmd_go ? addr : 30'd0;

    // Burst bookkeeping: beats remaining, pixel position, address advance and frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= BASE_ADDR;
            words_left  <= '0;
            pixel_idx   <= '0;
            frame_count <= '0;
        end else begin
            if (cmd_go) begin
                words_left <= BURST_WORDS;
            end else if (load) begin
                words_left <= words_left - 1'b1;
            end
            if (load) begin
                pixel_idx <= (pixel_idx == LAST_PIX) ? '0 : pixel_idx + 1'b1;
            end
            if (state == ST_STREAM && words_left == '0) begin
                if (pixel_idx == '0) begin
                    addr        <= BASE_ADDR;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    addr <= addr + BURST_BYTES;
                end
            end
        end
    end

    // Sticky MCB error flag and registered calibration status for the LEDs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            calib_q    <= 1'b0;
        end else begin
            calib_q <= c3_calib_done;
            if (c3_p1_rd_overflow || c3_p1_rd_error) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign led = {frame_count, err_sticky, calib_q};

    axis_out_reg #(
        .WIDTH (RGB_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .din     (c3_p1_rd_data[RGB_WIDTH-1:0]),
        .user_in (pixel_idx == '0),
        .last_in (pixel_idx == LAST_PIX),
        .tready  (m_axis_tready),
        .tdata   (m_axis_tdata),
        .tvalid  (m_axis_tvalid),
        .tuser   (m_axis_tuser),
        .tlast   (m_axis_tlast)
    );

endmodule

// File: tb/tb_ddr_to_rgb.sv
// Bench for ddr_to_rgb: an MCB port model returning word = byte_addr/4 + beat,
// and a pixel model where pixel k of a frame is base/4 + k with SOF/EOF flags.
module tb_ddr_to_rgb;

    localparam int RGB_W = 24;
    localparam int BURST = 64;
    localparam int FRAME = 128;
    localparam int BASE  = 32'h100;

    logic              clk;
    logic              rst_n;
    logic              c3_calib_done;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [29:0]       cmd_addr;
    logic              cmd_empty;
    logic              cmd_full;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic              rd_empty;
    logic              rd_full;
    logic [6:0]        rd_count;
    logic              rd_overflow;
    logic              rd_error;
    logic [RGB_W-1:0]  tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;
    logic [7:0]        led;

    ddr_to_rgb #(
        .RGB_WIDTH       (RGB_W),
        .BURST_LEN       (BURST),
        .FRAME_WORDS     (FRAME),
        .FRAME_BASE_ADDR (BASE)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .c3_calib_done       (c3_calib_done),
        .c3_p1_cmd_en        (cmd_en),
        .c3_p1_cmd_instr     (cmd_instr),
        .c3_p1_cmd_bl        (cmd_bl),
        .c3_p1_cmd_byte_addr (cmd_addr),
        .c3_p1_cmd_empty     (cmd_empty),
        .c3_p1_cmd_full      (cmd_full),
        .c3_p1_rd_en         (rd_en),
        .c3_p1_rd_data       (rd_data),
        .c3_p1_rd_empty      (rd_empty),
        .c3_p1_rd_full       (rd_full),
        .c3_p1_rd_count      (rd_count),
        .c3_p1_rd_overflow   (rd_overflow),
        .c3_p1_rd_error      (rd_error),
        .m_axis_tdata        (tdata),
        .m_axis_tvalid       (tvalid),
        .m_axis_tready       (tready),
        .m_axis_tuser        (tuser),
        .m_axis_tlast        (tlast),
        .led                 (led)
    );

    int total = 0;
    int bad   = 0;

    // MCB model state
    logic [31:0] fifo[$];
    logic [29:0] cmd_q[$];
    logic [29:0] cmd_log[$];
    logic [29:0] last_cmd_addr;
    int          lat;
    int          gen_left;
    logic [31:0] gen_word;
    int          cmd_idx;
    int          pops_since_rel;

    // Pixel model state
    int          k;
    logic [31:0] cap0;
    logic [31:0] cap127;
    logic [31:0] cap128;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic calib, input logic rdy, input logic err);
        @(posedge clk);
        #2;
        c3_calib_done = calib;
        tready        = rdy;
        rd_error      = err;
    endtask

    task automatic waitPixels(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (k >= n) break;
        end
        checkOutput(name, 32'(k >= n), 32'd1);
    endtask

    task automatic waitCmds(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (cmd_idx >= n) break;
        end
        checkOutput(name, 32'(cmd_idx >= n), 32'd1);
    endtask

    // MCB port-1 model: 4-cycle command latency, bursty word return, FWFT read FIFO
    initial begin : mcb_model
        logic        pop_s;
        logic        cmd_s;
        logic [29:0] addr_s;
        logic [2:0]  instr_s;
        logic [5:0]  bl_s;
        rd_empty = 1'b1; rd_count = 7'd0; rd_data = 32'd0; cmd_empty = 1'b1;
        cmd_full = 1'b0; rd_full = 1'b0; rd_overflow = 1'b0;
        lat = 0; gen_left = 0; gen_word = 32'd0; cmd_idx = 0; pops_since_rel = 0;
        last_cmd_addr = 30'd0;
        forever begin
            @(negedge clk);
            pop_s   = rd_en;
            cmd_s   = cmd_en;
            addr_s  = cmd_addr;
            instr_s = cmd_instr;
            bl_s    = cmd_bl;
            @(posedge clk);
            #1;
            if (pop_s) begin
                if (fifo.size() == 0) checkOutput("pop_nonempty", 32'd0, 32'd1);
                else void'(fifo.pop_front());
                pops_since_rel++;
            end
            if (cmd_s) begin
                checkOutput("one_burst_outstanding",
                            32'(fifo.size() == 0 && gen_left == 0 && cmd_q.size() == 0), 32'd1);
                checkOutput("cmd_instr", 32'(instr_s), 32'd1);
                checkOutput("cmd_bl", 32'(bl_s), 32'd63);
                checkOutput("cmd_addr", 32'(addr_s), 32'(BASE + (cmd_idx % 2) * 256));
                cmd_idx++;
                cmd_log.push_back(addr_s);
                last_cmd_addr = addr_s;
                cmd_q.push_back(addr_s);
                lat = 4;
            end else if (cmd_q.size() != 0 && gen_left == 0) begin
                if (lat > 0) lat--;
                else begin
                    gen_word = 32'(cmd_q.pop_front() >> 2);
                    gen_left = BURST;
                end
            end
            if (gen_left > 0 && $urandom_range(3) != 0) begin
                fifo.push_back(gen_word);
                gen_word++;
                gen_left--;
            end
            rd_empty  = (fifo.size() == 0);
            rd_data   = (fifo.size() != 0) ? fifo[0] : 32'd0;
            rd_count  = 7'(fifo.size());
            cmd_empty = (cmd_q.size() == 0);
        end
    end

    // Compare process: every handshake against the pixel model; stalled beats must hold
    initial begin : compare
        logic        hold;
        logic [31:0] hold_word;
        logic [31:0] cur;
        k = 0; hold = 1'b0; hold_word = 32'd0;
        cap0 = 32'd0; cap127 = 32'd0; cap128 = 32'd0;
        forever begin
            @(negedge clk);
            cur = 32'({tuser, tlast, tdata});
            if (!rst_n) begin
                k    = 0;
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checkOutput("stall_valid", 32'(tvalid), 32'd1);
                    checkOutput("stall_hold", cur, hold_word);
                end
                if (tvalid && tready) begin
                    checkOutput("pix_data", 32'(tdata), 32'(BASE / 4 + k % FRAME));
                    checkOutput("pix_tuser", 32'(tuser), 32'(k % FRAME == 0));
                    checkOutput("pix_tlast", 32'(tlast), 32'(k % FRAME == FRAME - 1));
                    if (k == 0)   cap0   = cur;
                    if (k == 127) cap127 = cur;
                    if (k == 128) cap128 = cur;
                    k++;
                end
                hold      = tvalid && !tready;
                hold_word = cur;
            end
        end
    end

    // Main sequence
    initial begin : main_seq
        logic seen_cmd;
        logic seen_valid;
        logic seen_rd;
        int   c0;
        int   k0;
        rst_n = 1'b0; c3_calib_done = 1'b0; tready = 1'b0; rd_error = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_tvalid", 32'(tvalid), 32'd0);
        checkOutput("reset_cmd_en", 32'(cmd_en), 32'd0);
        checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
        checkOutput("reset_led", 32'(led), 32'd0);
        rst_n = 1'b1;

        // calibration held low: nothing must happen
        seen_cmd = 1'b0; seen_valid = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (cmd_en) seen_cmd = 1'b1;
            if (tvalid) seen_valid = 1'b1;
        end
        checkOutput("no_cmd_before_calib", 32'(seen_cmd), 32'd0);
        checkOutput("no_valid_before_calib", 32'(seen_valid), 32'd0);
        checkOutput("led_calib_low", 32'(led[0]), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCmds(1, 100, "first_cmd_timeout");
        checkOutput("first_cmd_addr", 32'(last_cmd_addr), 32'h100);
        checkOutput("led_calib_high", 32'(led[0]), 32'd1);

        // three frames at full rate
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitPixels(384, 3000, "three_frames_timeout");
        repeat (4) @(posedge clk);
        #2;
        checkOutput("led_frame_count", 32'(led[7:2]), 32'd3);
        checkOutput("pin_pixel0", cap0, 32'h0200_0040);
        checkOutput("pin_pixel127", cap127, 32'h0100_00BF);
        checkOutput("pin_pixel128", cap128, 32'h0200_0040);
        checkOutput("pin_cmd1_addr", 32'(cmd_log.size() > 1 ? cmd_log[1] : 30'd0), 32'h200);
        checkOutput("pin_cmd2_addr", 32'(cmd_log.size() > 2 ? cmd_log[2] : 30'd0), 32'h100);

        // random back-pressure
        for (int i = 0; i < 6000; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0);
            if (k >= 768) break;
        end
        checkOutput("random_ready_timeout", 32'(k >= 768), 32'd1);

        // long stall in the middle of a burst
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            if (k % 64 == 20) break;
        end
        tready = 1'b0;
        c0 = cmd_idx;
        seen_rd = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        k0 = k;
        repeat (197) begin
            @(negedge clk);
            if (rd_en || cmd_en) seen_rd = 1'b1;
        end
        checkOutput("stall_no_rd_or_cmd", 32'(seen_rd), 32'd0);
        checkOutput("stall_no_new_cmd", 32'(cmd_idx), 32'(c0));
        checkOutput("stall_no_pixels", 32'(k), 32'(k0));
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitPixels(k0 + 100, 1000, "resume_timeout");

        // sticky error
        k0 = k;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("led_error_set", 32'(led[1]), 32'd1);
        repeat (30) @(posedge clk);
        #2;
        checkOutput("led_error_sticky", 32'(led[1]), 32'd1);
        checkOutput("stream_after_error", 32'(k > k0 + 10), 32'd1);

        // reset mid-burst with 20 words stranded in the read FIFO
        c0 = cmd_idx;
        waitCmds(c0 + 1, 500, "pre_reset_cmd_timeout");
        tready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (gen_left == 0 && cmd_q.size() == 0 && fifo.size() >= 40) break;
        end
        tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (fifo.size() == 20) break;
        end
        checkOutput("fifo_at_20", 32'(fifo.size()), 32'd20);
        rst_n = 1'b0;
        cmd_idx = 0;
        #1;
        checkOutput("rst_tvalid_now", 32'(tvalid), 32'd0);
        checkOutput("rst_tdata_now", 32'({tuser, tlast, tdata}), 32'd0);
        checkOutput("rst_cmd_rd_now", 32'({cmd_en, rd_en}), 32'd0);
        checkOutput("rst_led_now", 32'(led), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        cap0 = 32'd0;
        pops_since_rel = 0;
        rst_n = 1'b1;
        waitCmds(1, 300, "post_reset_cmd_timeout");
        checkOutput("flush_pops", 32'(pops_since_rel), 32'd20);
        checkOutput("post_reset_addr", 32'(last_cmd_addr), 32'h100);
        waitPixels(1, 300, "post_reset_pixel_timeout");
        checkOutput("post_reset_first_pixel", cap0, 32'h0200_0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
